// File: rtl/ps2_host_tx_if.sv
// Transmit-side handshake bundle for ps2_host_tx: byte request in, ready/done/err status out.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       done;
    logic       err;

    modport master (output tx_data, output tx_valid, input tx_ready, input done, input err);
    modport slave  (input tx_data, input tx_valid, output tx_ready, output done, output err);
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 11 device-clocked bits and ACK.
// Optional macro PS2_TX_ACK_CHECK_EN turns a missing device ACK into an err pulse.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic         clk,
    input  logic         rst,
    ps2_host_tx_if.slave tx,
    input  logic         ps2_clk_in,
    input  logic         ps2_data_in,
    output logic         ps2_clk_oe,
    output logic         ps2_data_oe
);
    localparam int INH_W = $clog2(INHIBIT_CYCLES);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_XFER,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         shreg_q, shreg_d;
    logic               par_q, par_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic [INH_W-1:0]   inh_cnt_q, inh_cnt_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic               clk_oe_q, clk_oe_d;
    logic               data_oe_q, data_oe_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [1:0]         clk_sync_q, clk_sync_d;
    logic [1:0]         data_sync_q, data_sync_d;
    logic               clk_prev_q, clk_prev_d;

    logic clk_s;
    logic data_s;
    logic fe;
    logic tmo_hit;

    // Pads idle high, so synchronizers reset to 1 to avoid a phantom edge after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            shreg_q     <= '0;
            par_q       <= 1'b0;
            bit_cnt_q   <= '0;
            inh_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            clk_oe_q    <= 1'b0;
            data_oe_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            par_q       <= par_d;
            bit_cnt_q   <= bit_cnt_d;
            inh_cnt_q   <= inh_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            clk_oe_q    <= clk_oe_d;
            data_oe_q   <= data_oe_d;
            done_q      <= done_d;
            err_q       <= err_d;
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            clk_prev_q  <= clk_prev_d;
        end
    end

    assign clk_s   = clk_sync_q[1];
    assign data_s  = data_sync_q[1];
    assign fe      = clk_prev_q & ~clk_s;
    assign tmo_hit = (tmo_cnt_q == TMO_LAST);

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        par_d       = par_q;
        bit_cnt_d   = bit_cnt_q;
        inh_cnt_d   = inh_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        clk_oe_d    = clk_oe_q;
        data_oe_d   = data_oe_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        clk_sync_d  = {clk_sync_q[0], ps2_clk_in};
        data_sync_d = {data_sync_q[0], ps2_data_in};
        clk_prev_d  = clk_s;

        if (state_q == S_XFER || state_q == S_ACK || state_q == S_WAIT_IDLE) begin
            tmo_cnt_d = fe ? '0 : tmo_cnt_q + TMO_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (tx.tx_valid) begin
                    shreg_d   = tx.tx_data;
                    par_d     = ~^tx.tx_data;
                    bit_cnt_d = '0;
                    inh_cnt_d = '0;
                    clk_oe_d  = 1'b1;
                    data_oe_d = 1'b0;
                    state_d   = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (inh_cnt_q == INH_LAST) begin
                    data_oe_d = 1'b1;
                    state_d   = S_REQ;
                end else begin
                    inh_cnt_d = inh_cnt_q + INH_W'(1);
                end
            end
            S_REQ: begin
                clk_oe_d  = 1'b0;
                tmo_cnt_d = '0;
                state_d   = S_XFER;
            end
            // Start bit stays driven until the first device falling edge.
            S_XFER: begin
                if (fe) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q < 4'd8) begin
                        data_oe_d = ~shreg_q[0];
                        shreg_d   = {1'b0, shreg_q[7:1]};
                    end else if (bit_cnt_q == 4'd8) begin
                        data_oe_d = ~par_q;
                    end else begin
                        data_oe_d = 1'b0;
                        state_d   = S_ACK;
                    end
                end else if (tmo_hit) begin
                    data_oe_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_ACK: begin
                if (fe) begin
`ifdef PS2_TX_ACK_CHECK_EN
                    if (data_s) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WAIT_IDLE;
                    end
`else
                    state_d = S_WAIT_IDLE;
`endif
                end else if (tmo_hit) begin
                    data_oe_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_WAIT_IDLE: begin
                if (clk_s && data_s) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (tmo_hit) begin
                    data_oe_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    assign tx.tx_ready = (state_q == S_IDLE);
    assign tx.done     = done_q;
    assign tx.err      = err_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: device-side PS/2 model, vector table, randomized sends and corner sequences.
module tb_ps2_host_tx;
    localparam int INH  = 20;
    localparam int TMO  = 400;
    localparam int HALF = 30;

`ifdef PS2_TX_ACK_CHECK_EN
    localparam bit ACK_CHECK = 1'b1;
`else
    localparam bit ACK_CHECK = 1'b0;
`endif

    typedef struct {
        logic [7:0] data;
        bit         ack;
        logic       exp_par;
        int         exp_done;
        int         exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ps2_clk_oe;
    logic ps2_data_oe;
    logic dev_clk = 1'b1;
    logic dev_data = 1'b1;
    logic ps2_clk_in;
    logic ps2_data_in;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;

    ps2_host_tx_if bus ();

    // Open-drain pads: low if either side pulls low.
    assign ps2_clk_in  = ~ps2_clk_oe & dev_clk;
    assign ps2_data_in = ~ps2_data_oe & dev_data;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx         (bus),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.done) done_cnt++;
        if (bus.err) err_cnt++;
        if (bus.done && bus.err) both_cnt++;
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation exceeded time limit, got running expected finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected frame from protocol rules: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] refFrame(input logic [7:0] d);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = d[i];
        f[9]  = ($countones(d) % 2 == 0) ? 1'b1 : 1'b0;
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic sendByte(input logic [7:0] d);
        int n = 0;
        @(negedge clk);
        while (!bus.tx_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("ready_before_send", 32'(bus.tx_ready), 32'd1);
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_valid = 1'b0;
    endtask

    // Device model: measures inhibit, clocks n_edges bits in, then optionally ACKs.
    task automatic runDevice(input int n_edges, input bit give_ack, output logic [10:0] cap,
                             output int low_cycles, output int req_cycles);
        int n = 0;
        cap = '1;
        low_cycles = 0;
        req_cycles = 0;
        while (!ps2_clk_oe && n < 100) begin
            @(negedge clk);
            n++;
        end
        while (ps2_clk_oe && low_cycles < 10 * INH) begin
            if (ps2_data_oe) req_cycles++;
            low_cycles++;
            @(negedge clk);
        end
        cap[0] = ps2_data_in;
        if (n_edges == 0) return;
        repeat (10) @(negedge clk);
        for (int i = 1; i <= n_edges; i++) begin
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            cap[i] = ps2_data_in;
            dev_clk = 1'b1;
            repeat (HALF) @(negedge clk);
        end
        if (n_edges < 10) return;
        bus.tx_valid = 1'b0;
        if (give_ack) dev_data = 1'b0;
        repeat (5) @(negedge clk);
        dev_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        dev_clk = 1'b1;
        repeat (5) @(negedge clk);
        dev_data = 1'b1;
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        while (!bus.tx_ready && n < 2 * TMO) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, "_ready_after"}, 32'(bus.tx_ready), 32'd1);
        repeat (5) @(negedge clk);
    endtask

    task automatic applyStimulus(input vec_t v, input string name);
        logic [10:0] cap;
        int low, req, d0, e0;
        d0 = done_cnt;
        e0 = err_cnt;
        sendByte(v.data);
        runDevice(10, v.ack, cap, low, req);
        waitIdle(name);
        checkOutput({name, "_inhibit_len"}, 32'(low), 32'(INH + 1));
        checkOutput({name, "_req_len"}, 32'(req), 32'd1);
        checkOutput({name, "_start"}, 32'(cap[0]), 32'd0);
        checkOutput({name, "_data"}, 32'(cap[8:1]), 32'(v.data));
        checkOutput({name, "_parity"}, 32'(cap[9]), 32'(v.exp_par));
        checkOutput({name, "_stop"}, 32'(cap[10]), 32'd1);
        checkOutput({name, "_done"}, 32'(done_cnt - d0), 32'(v.exp_done));
        checkOutput({name, "_err"}, 32'(err_cnt - e0), 32'(v.exp_err));
    endtask

    initial begin
        vec_t table_v[5];
        vec_t rv;
        logic [10:0] cap;
        logic [10:0] ref_f;
        int low, req, d0, e0, n, seen;

        table_v[0] = '{8'hED, 1'b1, 1'b1, 1, 0};
        table_v[1] = '{8'h01, 1'b1, 1'b0, 1, 0};
        table_v[2] = '{8'h00, 1'b1, 1'b1, 1, 0};
        table_v[3] = '{8'hA5, 1'b0, 1'b1, ACK_CHECK ? 0 : 1, ACK_CHECK ? 1 : 0};
        table_v[4] = '{8'hF0, 1'b1, 1'b1, 1, 0};

        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_ready", 32'(bus.tx_ready), 32'd1);
        checkOutput("rst_done", 32'(bus.done), 32'd0);
        checkOutput("rst_err", 32'(bus.err), 32'd0);
        checkOutput("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        checkOutput("rst_data_oe", 32'(ps2_data_oe), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(table_v[i], $sformatf("vec%0d", i));
        end

        // No device clocking: err exactly TMO cycles after XFER entry.
        d0 = done_cnt;
        e0 = err_cnt;
        sendByte(8'h3C);
        runDevice(0, 1'b0, cap, low, req);
        n = 0;
        while (!bus.err && n < 2 * TMO) begin
            @(negedge clk);
            n++;
        end
        checkOutput("tmo_cycles", 32'(n), 32'(TMO));
        checkOutput("tmo_clk_oe", 32'(ps2_clk_oe), 32'd0);
        checkOutput("tmo_data_oe", 32'(ps2_data_oe), 32'd0);
        checkOutput("tmo_ready", 32'(bus.tx_ready), 32'd1);
        repeat (5) @(negedge clk);
        checkOutput("tmo_done", 32'(done_cnt - d0), 32'd0);
        checkOutput("tmo_err", 32'(err_cnt - e0), 32'd1);

        // A second request during an in-flight frame is dropped, not queued.
        d0 = done_cnt;
        e0 = err_cnt;
        sendByte(8'hF4);
        bus.tx_data  = 8'h55;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        checkOutput("busy_ready", 32'(bus.tx_ready), 32'd0);
        runDevice(10, 1'b1, cap, low, req);
        waitIdle("busy");
        checkOutput("busy_data", 32'(cap[8:1]), 32'hF4);
        checkOutput("busy_done", 32'(done_cnt - d0), 32'd1);
        seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (ps2_clk_oe) seen++;
        end
        checkOutput("busy_no_second", 32'(seen), 32'd0);

        // Reset during inhibit releases the clock line.
        sendByte(8'h12);
        repeat (3) @(negedge clk);
        checkOutput("inh_clk_oe", 32'(ps2_clk_oe), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("inh_rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        repeat (5) @(negedge clk);

        // Reset after the 4th data bit of 0x00 releases a driven data line.
        d0 = done_cnt;
        e0 = err_cnt;
        sendByte(8'h00);
        runDevice(4, 1'b0, cap, low, req);
        checkOutput("mid_data_oe", 32'(ps2_data_oe), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("mid_rst_data_oe", 32'(ps2_data_oe), 32'd0);
        checkOutput("mid_rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        repeat (20) @(negedge clk);
        checkOutput("mid_rst_done", 32'(done_cnt - d0), 32'd0);
        checkOutput("mid_rst_err", 32'(err_cnt - e0), 32'd0);
        applyStimulus('{8'hFF, 1'b1, 1'b1, 1, 0}, "after_rst");

        // Randomized bytes and ACK behaviour against the frame model.
        for (int i = 0; i < 6; i++) begin
            rv.data     = 8'($urandom_range(0, 255));
            rv.ack      = ($urandom_range(0, 3) != 0);
            ref_f       = refFrame(rv.data);
            rv.exp_par  = ref_f[9];
            rv.exp_done = (rv.ack || !ACK_CHECK) ? 1 : 0;
            rv.exp_err  = (rv.ack || !ACK_CHECK) ? 0 : 1;
            applyStimulus(rv, $sformatf("rnd%0d", i));
        end

        checkOutput("done_err_overlap", 32'(both_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to the keyboard on the same PS2_CLK/PS2_DATA pair the keyboard receive path listens on. It runs the inhibit/request-to-send sequence, shifts 8 data bits LSB-first plus odd parity and stop on device-generated clock edges, and checks the device ACK. The top level turns its open-drain enables into tri-state drives, with `PS2_CLK = ps2_clk_oe ? 1'b0 : 1'bz` and the same form for `PS2_DATA`. It also uses the `*_in` inputs to read back the pads.

## Interface
- `INHIBIT_CYCLES`, default 12000: `clk` cycles that PS2_CLK is held low, which is 120 µs at 100 MHz.
- `TIMEOUT_CYCLES`, default 2000000: maximum `clk` cycles between device clock falling edges, which is 20 ms at 100 MHz.
- `clk` input, 1 bit: system clock at 100 MHz. All logic is on its rising edge.
- `rst` input, 1 bit: reset is synchronous and active-high.
- `tx_data` input, 8 bits: byte to send. It is sampled on the accept cycle.
- `tx_valid` input, 1 bit: send request.
- `tx_ready` output, 1 bit: high only in IDLE. A transfer is accepted when `tx_valid && tx_ready`.
- `done` output, 1 bit: one-cycle pulse on successful completion.
- `err` output, 1 bit: one-cycle pulse on a timeout or a missing ACK.
- `ps2_clk_in` input, 1 bit: raw PS2_CLK pad value, asynchronous.
- `ps2_data_in` input, 1 bit: raw PS2_DATA pad value, asynchronous.
- `ps2_clk_oe` output, 1 bit: 1 drives PS2_CLK low, 0 releases it.
- `ps2_data_oe` output, 1 bit: 1 drives PS2_DATA low, 0 releases it.

## Operation
- Each pad input passes through a 2-FF synchronizer. A falling edge (`fe`) is detected when the previous synchronized value is 1 and the current one is 0.
- On accept, the block latches `tx_data` into `shreg` and computes `par = ~^tx_data` (odd parity). The bit counter is cleared.
- States:
  - IDLE: both `oe` are 0 and `tx_ready` is 1. It moves to INHIBIT on accept.
  - INHIBIT: `ps2_clk_oe` is 1 for exactly `INHIBIT_CYCLES` cycles, then it moves to REQ.
  - REQ: `ps2_clk_oe` is 1 and `ps2_data_oe` is 1 for 1 cycle. This is the start bit, driven low. It then moves to XFER.
  - XFER: `ps2_clk_oe` is 0. On each `fe`, the block presents the next bit with `ps2_data_oe = ~bit`:
    - edges 1–8 present `shreg[0..7]`;
    - edge 9 presents `par`;
    - edge 10 releases data (stop bit = 1) and moves to ACK.
  - ACK: on the next `fe`, it samples synchronized data. 0 means ACK. It then moves to WAIT_IDLE. Without an ACK it raises `err` (see Configuration).
  - WAIT_IDLE: it waits until synchronized clock and data are both 1, then pulses `done` and returns to IDLE.
- The timeout counter clears on entry to XFER and on every `fe`. If it reaches `TIMEOUT_CYCLES` in XFER, ACK or WAIT_IDLE, the block releases both lines, pulses `err` and returns to IDLE next cycle. `done` is not pulsed in that case.
- `done` and `err` never assert in the same cycle.
- `tx_valid` while `tx_ready` = 0 is ignored. It is not queued.
- Edges seen in IDLE, INHIBIT or REQ (device traffic, own inhibit) are ignored.
- The block does not arbitrate against a concurrent device-to-host frame. The caller issues sends only when the receive path is idle.

## Timing
- Reset values: state IDLE, `tx_ready` 1, `done` 0, `err` 0, `ps2_clk_oe` 0, `ps2_data_oe` 0, counters 0.
- `rst` asserted mid-transfer releases both lines on the cycle after the `rst` edge. No `done` or `err` pulse is produced.
- Accept at cycle T:
  - `ps2_clk_oe` rises at T+1 and stays 1 through T+`INHIBIT_CYCLES`.
  - REQ occupies the following cycle.
  - `ps2_clk_oe` falls on the cycle after that, with `ps2_data_oe` still 1.
- `fe` is seen 2 cycles after the pad edge, due to sync and edge detect. Data `oe` updates on the cycle after `fe` is seen, which is 3 cycles after the pad edge. This is far inside the device's ≥5 µs clock-low phase.
- Counter widths are `$clog2` of the respective parameter. Bit counter is 4 bits, range 0–10.

## Configuration
- Macro `PS2_TX_ACK_CHECK_EN`.
- Defined: in ACK, sampled data 1 pulses `err` (not `done`) and the block returns to IDLE after releasing the lines.
- Undefined: the ACK sample is ignored. The 11th `fe` always leads to WAIT_IDLE and `done`.
- The timeout behaviour is identical in both builds.

## Test plan
- Send 0xED with a device model that clocks at 12.5 kHz and ACKs:
  - clock held low ≥ `INHIBIT_CYCLES`;
  - the model captures start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1;
  - `done` pulses once and `tx_ready` returns to 1.
- Send 0x01 and then 0x00 back-to-back: captured parity is 0 then 1, with two `done` pulses.
- No device clocking after REQ: `err` pulses exactly `TIMEOUT_CYCLES` cycles after XFER entry, both `oe` are 0 and `tx_ready` is 1.
- The device omits the ACK (data stays high on the 11th edge):
  - with `PS2_TX_ACK_CHECK_EN` defined, `err` pulses and there is no `done`;
  - undefined, `done` pulses.
- `tx_valid` with 0x55 asserted during an in-flight 0xF4 transfer: only 0xF4 is captured and one `done` is produced.
- `rst` pulsed after the 4th data bit: both `oe` are 0 the next cycle, no pulses appear, and a fresh 0xFF send afterwards completes correctly.
